// File: rtl/cpu_bus_serializer.sv
// Bridges a wide CPU bus transaction onto PIN_W-bit pins: address beats, a command beat,
// optional write-data beats, a ready wait with timeout, then read-data capture.
module cpu_bus_serializer #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int PIN_W    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic [PIN_W-1:0]  pin_out,
    output logic              pin_strobe,
    output logic [PIN_W-1:0]  pin_dout,
    output logic [PIN_W-1:0]  pin_oe,
    input  logic [PIN_W-1:0]  pin_din,
    input  logic              pin_ready
);

    localparam int ABEATS = ADDR_W / PIN_W;
    localparam int DBEATS = DATA_W / PIN_W;
    localparam int MAXB   = (ABEATS > DBEATS) ? ABEATS : DBEATS;
    localparam int CNT_W  = $clog2(MAXB + 1);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CMD   = 3'd2,
        S_WDATA = 3'd3,
        S_WAIT  = 3'd4,
        S_RDATA = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                tmo_d;
    logic [PIN_W-1:0]    pin_out_q, pin_out_d;
    logic                strobe_q, strobe_d;
    logic [PIN_W-1:0]    dout_q, dout_d;
    logic [PIN_W-1:0]    oe_q, oe_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            pin_out_q <= '0;
            strobe_q  <= 1'b0;
            dout_q    <= '0;
            oe_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            pin_out_q <= pin_out_d;
            strobe_q  <= strobe_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        tmo_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    beat_d  = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (beat_q == CNT_W'(ABEATS - 1)) begin
                    beat_d  = '0;
                    state_d = S_CMD;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_CMD: begin
                beat_d  = '0;
                wait_d  = '0;
                state_d = we_q ? S_WDATA : S_WAIT;
            end
            S_WDATA: begin
                if (beat_q == CNT_W'(DBEATS - 1)) begin
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (pin_ready) begin
                    beat_d  = '0;
                    state_d = we_q ? S_DONE : S_RDATA;
                end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RDATA: begin
                shift_d[int'(beat_q)*PIN_W +: PIN_W] = pin_din;
                if (beat_q == CNT_W'(DBEATS - 1)) begin
                    rdata_d = shift_d;
                    beat_d  = '0;
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        pin_out_d = '0;
        strobe_d  = 1'b0;
        dout_d    = '0;
        oe_d      = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = (state_d != S_IDLE);
        case (state_d)
            S_ADDR: begin
                pin_out_d = addr_d[int'(beat_d)*PIN_W +: PIN_W];
                strobe_d  = 1'b1;
            end
            S_CMD: begin
                pin_out_d = PIN_W'(2) | PIN_W'(we_d);
                strobe_d  = 1'b1;
            end
            S_WDATA: begin
                dout_d   = wdata_d[int'(beat_d)*PIN_W +: PIN_W];
                oe_d     = '1;
                strobe_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                err_d  = tmo_d;
            end
            default: ;
        endcase
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_done   = done_q;
    assign cpu_err    = err_q;
    assign cpu_busy   = busy_q;
    assign pin_out    = pin_out_q;
    assign pin_strobe = strobe_q;
    assign pin_dout   = dout_q;
    assign pin_oe     = oe_q;

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// Bench for cpu_bus_serializer: per-edge pin/CPU expectations derived from beat lists and
// cycle arithmetic, plus a narrow 16/16/4 instance with back-to-back requests.
module tb_cpu_bus_serializer;

    localparam int AW = 32, DW = 32, PW = 8, WM = 15;
    localparam int AB = AW / PW, DB = DW / PW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_done, cpu_err, cpu_busy;
    logic [PW-1:0] pin_out, pin_dout, pin_oe, pin_din;
    logic          pin_strobe, pin_ready;

    cpu_bus_serializer #(.ADDR_W(AW), .DATA_W(DW), .PIN_W(PW), .WAIT_MAX(WM)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .pin_out(pin_out), .pin_strobe(pin_strobe), .pin_dout(pin_dout), .pin_oe(pin_oe),
        .pin_din(pin_din), .pin_ready(pin_ready)
    );

    logic        s_req, s_we, s_done, s_err, s_busy, s_strobe, s_ready;
    logic [15:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_out, s_dout, s_oe, s_din;

    cpu_bus_serializer #(.ADDR_W(16), .DATA_W(16), .PIN_W(4), .WAIT_MAX(3)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(s_req), .cpu_we(s_we), .cpu_addr(s_addr), .cpu_wdata(s_wdata),
        .cpu_rdata(s_rdata), .cpu_done(s_done), .cpu_err(s_err), .cpu_busy(s_busy),
        .pin_out(s_out), .pin_strobe(s_strobe), .pin_dout(s_dout), .pin_oe(s_oe),
        .pin_din(s_din), .pin_ready(s_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] rd_model;
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, 64'(pin_out), 64'd0);
        chk({tag, "_stb"}, 64'(pin_strobe), 64'd0);
        chk({tag, "_dout"}, 64'(pin_dout), 64'd0);
        chk({tag, "_oe"}, 64'(pin_oe), 64'd0);
        chk({tag, "_done"}, 64'(cpu_done), 64'd0);
        chk({tag, "_err"}, 64'(cpu_err), 64'd0);
        chk({tag, "_busy"}, 64'(cpu_busy), 64'd0);
        chk({tag, "_rdata"}, 64'(cpu_rdata), 64'd0);
    endtask

    // Edge 0 is the accept edge; k is the number of ready-low WAIT samples (>=WM means timeout).
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int k, input int abort_e, input bit fix_din,
                           input logic [DW-1:0] din_pat);
        int ws, done_e;
        logic tmo;
        logic [PW-1:0] din_at[64];
        logic rdy_at[64];
        logic [DW-1:0] new_rd, t;
        logic [PW-1:0] x_out, x_dout, x_oe;
        logic x_stb;
        ws     = we ? AB + DB + 2 : AB + 2;
        tmo    = (k >= WM);
        done_e = tmo ? ws + WM - 1 : (we ? ws + k : ws + k + DB);
        for (int e = 0; e < 64; e++) begin
            din_at[e] = PW'($urandom);
            rdy_at[e] = 1'($urandom_range(0, 1));
        end
        for (int e = ws; e < ws + k && e < 64; e++) rdy_at[e] = 1'b0;
        if (!tmo) rdy_at[ws + k] = 1'b1;
        if (fix_din && !tmo)
            for (int j = 0; j < DB; j++) din_at[ws + k + 1 + j] = din_pat[j*PW +: PW];
        new_rd = rd_model;
        if (!we && !tmo)
            for (int j = 0; j < DB; j++) new_rd[j*PW +: PW] = din_at[ws + k + 1 + j];

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        pin_din = din_at[0]; pin_ready = rdy_at[0];
        for (int e = 0; e <= done_e + 1; e++) begin
            @(negedge clk);
            x_out = '0; x_dout = '0; x_oe = '0; x_stb = 1'b0;
            if (e < AB) begin
                t = addr >> (e * PW); x_out = t[PW-1:0]; x_stb = 1'b1;
            end else if (e == AB) begin
                x_out = we ? 8'h03 : 8'h02; x_stb = 1'b1;
            end else if (we && e <= AB + DB) begin
                t = wdata >> ((e - AB - 1) * PW); x_dout = t[PW-1:0]; x_oe = 8'hFF; x_stb = 1'b1;
            end
            chk($sformatf("out@%0d", e), 64'(pin_out), 64'(x_out));
            chk($sformatf("stb@%0d", e), 64'(pin_strobe), 64'(x_stb));
            chk($sformatf("dout@%0d", e), 64'(pin_dout), 64'(x_dout));
            chk($sformatf("oe@%0d", e), 64'(pin_oe), 64'(x_oe));
            chk($sformatf("done@%0d", e), 64'(cpu_done), 64'(e == done_e));
            chk($sformatf("busy@%0d", e), 64'(cpu_busy), 64'(e <= done_e));
            chk($sformatf("rdata@%0d", e), 64'(cpu_rdata), 64'((e >= done_e) ? new_rd : rd_model));
            if (e == done_e) chk($sformatf("err@%0d", e), 64'(cpu_err), 64'(tmo));
            if (e == abort_e) begin
                #2 rst_n = 1'b0;
                cpu_req = 1'b0;
                #1 chk_all_zero("rst_async");
                rd_model = '0;
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_hold_done", 64'(cpu_done), 64'd0);
                    chk("rst_hold_busy", 64'(cpu_busy), 64'd0);
                end
                rst_n = 1'b1;
                return;
            end
            cpu_req   = (e == done_e + 1) ? 1'b0 : 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            pin_din   = din_at[e + 1];
            pin_ready = rdy_at[e + 1];
        end
        rd_model = new_rd;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        pin_din = '0; pin_ready = 1'b0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_din = '0; s_ready = 1'b0;
        rd_model = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b1, 32'h12345678, 32'hCAFEBABE, 0, -1, 1'b0, '0);
        run_txn(1'b0, 32'h00000010, '0, 0, -1, 1'b1, 32'h44332211);
        chk("rd_direct", 64'(cpu_rdata), 64'h44332211);
        run_txn(1'b0, $urandom, '0, 3, -1, 1'b1, 32'hA5C3_0F96);
        run_txn(1'b0, $urandom, '0, WM, -1, 1'b0, '0);
        chk("rd_kept_after_tmo", 64'(cpu_rdata), 64'hA5C3_0F96);
        run_txn(1'b1, $urandom, $urandom, WM + 1, -1, 1'b0, '0);

        for (int i = 0; i < 14; i++) begin
            int r, k;
            r = $urandom_range(0, 9);
            k = (r == 9) ? WM + $urandom_range(0, 2) : $urandom_range(0, 4);
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, k, -1, 1'b0, '0);
        end

        run_txn(1'b1, $urandom, $urandom, 0, AB + 3, 1'b0, '0);
        run_txn(1'b1, 32'h89ABCDEF, 32'h01234567, 1, -1, 1'b0, '0);
        run_txn(1'b0, $urandom, '0, 2, -1, 1'b0, '0);

        // Narrow instance: request held high gives two back-to-back writes.
        s_addr = 16'hB7E4; s_wdata = 16'h3D91; s_we = 1'b1; s_ready = 1'b1;
        for (int tr = 0; tr < 2; tr++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(s_addr[i*4 +: 4]);
            exp_q.push_back(4'h3);
            for (int i = 0; i < 4; i++) exp_q.push_back(s_wdata[i*4 +: 4]);
        end
        s_req = 1'b1;
        for (int e = 0; e <= 23; e++) begin
            @(negedge clk);
            if (s_strobe) got_q.push_back((s_oe != 4'h0) ? s_dout : s_out);
            if (s_strobe && s_oe != 4'h0) chk($sformatf("s_oe@%0d", e), 64'(s_oe), 64'hF);
            chk($sformatf("s_done@%0d", e), 64'(s_done), 64'(e == 10 || e == 22));
            chk($sformatf("s_busy@%0d", e), 64'(s_busy), 64'(e != 11 && e != 23));
            if (e == 22) s_req = 1'b0;
        end
        chk("s_beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("s_beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

        // Narrow instance read timeout with WAIT_MAX=3.
        s_we = 1'b0; s_ready = 1'b0; s_req = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            @(negedge clk);
            if (e == 0) s_req = 1'b0;
            chk($sformatf("s_tdone@%0d", e), 64'(s_done), 64'(e == 8));
            chk($sformatf("s_tbusy@%0d", e), 64'(s_busy), 64'(e <= 8));
            if (e == 8) chk("s_terr", 64'(s_err), 64'd1);
        end
        chk("s_rdata_kept", 64'(s_rdata), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
